// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

  typedef enum logic {
    IDLE,
    PRESSED
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_cls_e;

  function automatic int code_w(input int n_row, input int n_col);
    return (n_row * n_col > 1) ? $clog2(n_row * n_col) : 1;
  endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Dwell divider and one-hot column ring; flags the last dwell cycle of each
// column (sample_strobe_o) and of the last column (frame_end_o).
module keypad_col_scanner #(
  parameter int N_COL    = 4,
  parameter int SCAN_DIV = 17,
  parameter int CI_W     = $clog2(N_COL)
) (
  input  logic             clk,
  input  logic             reset_p,
  output logic [N_COL-1:0] col_o,
  output logic [CI_W-1:0]  col_index_o,
  output logic             sample_strobe_o,
  output logic             frame_end_o
);

  logic [SCAN_DIV-1:0] div_q;
  logic [N_COL-1:0]    col_q;
  logic [CI_W-1:0]     idx_q;

  assign sample_strobe_o = &div_q;
  assign frame_end_o     = sample_strobe_o && (idx_q == CI_W'(N_COL - 1));
  assign col_o           = col_q;
  assign col_index_o     = idx_q;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      div_q <= '0;
      col_q <= N_COL'(1);
      idx_q <= '0;
    end else begin
      div_q <= div_q + SCAN_DIV'(1);
      if (sample_strobe_o) begin
        col_q <= {col_q[N_COL-2:0], col_q[N_COL-1]};
        idx_q <= frame_end_o ? '0 : idx_q + CI_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scan.sv
// N_ROW x N_COL key-matrix scanner with frame debounce and n-key lockout.
// Optional auto-repeat of key_press is compiled in with KEYPAD_REPEAT_EN.
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int N_ROW          = 4,
  parameter int N_COL          = 4,
  parameter int SCAN_DIV       = 17,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_RATE    = 4,
  localparam int CODE_W        = code_w(N_ROW, N_COL)
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic [N_ROW-1:0]  row,
  output logic [N_COL-1:0]  col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_press,
  output logic              key_release,
  output logic              multi_key
);

  localparam int CI_W   = $clog2(N_COL);
  localparam int RW     = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

  logic [CI_W-1:0] col_index;
  logic            sample_strobe;
  logic            frame_end;

  keypad_col_scanner #(
    .N_COL   (N_COL),
    .SCAN_DIV(SCAN_DIV),
    .CI_W    (CI_W)
  ) u_scan (
    .clk            (clk),
    .reset_p        (reset_p),
    .col_o          (col),
    .col_index_o    (col_index),
    .sample_strobe_o(sample_strobe),
    .frame_end_o    (frame_end)
  );

  kp_state_e          state_q;
  frame_cls_e         prev_cls_q;
  logic [CODE_W-1:0]  prev_code_q;
  logic [STAB_W-1:0]  stab_q;
  logic [1:0]         acc_cnt_q;
  logic [CODE_W-1:0]  acc_code_q;
  logic [CODE_W-1:0]  key_code_q;
  logic               valid_q, press_q, release_q, multi_q;

  logic [1:0]         row_cnt;
  logic [RW-1:0]      row_low;
  logic [CODE_W-1:0]  samp_code;
  logic [2:0]         cnt_sum;
  logic [1:0]         frame_cnt;
  logic [CODE_W-1:0]  frame_code;
  frame_cls_e         cls;
  logic [CODE_W-1:0]  code_eff;
  logic [STAB_W-1:0]  stab_d;

  // Closed switches in the current column, saturating at 2, plus the lowest row.
  always_comb begin
    row_cnt = 2'd0;
    row_low = '0;
    for (int r = N_ROW - 1; r >= 0; r--) begin
      if (row[r]) row_low = RW'(r);
    end
    for (int r = 0; r < N_ROW; r++) begin
      if (row[r] && row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
    end
  end

  // Frame summary including the sample being taken this cycle.
  always_comb begin
    samp_code  = CODE_W'(col_index) * CODE_W'(N_ROW) + CODE_W'(row_low);
    cnt_sum    = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
    frame_cnt  = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
    frame_code = (acc_cnt_q == 2'd0) ? samp_code : acc_code_q;
    cls        = NONE;
    if (frame_cnt == 2'd1)      cls = SINGLE;
    else if (frame_cnt == 2'd2) cls = MULTI;
    code_eff   = (cls == SINGLE) ? frame_code : '0;
    stab_d     = STAB_W'(1);
    if (cls == prev_cls_q && code_eff == prev_code_q)
      stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + STAB_W'(1);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_WRAP  = RP_W'(REPEAT_DELAY + REPEAT_RATE);
  logic [RP_W-1:0] rep_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY != REPEAT_RATE);
`endif

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q     <= IDLE;
      prev_cls_q  <= NONE;
      prev_code_q <= '0;
      stab_q      <= '0;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= '0;
      key_code_q  <= '0;
      valid_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      multi_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (sample_strobe && !frame_end) begin
        acc_cnt_q  <= frame_cnt;
        acc_code_q <= frame_code;
      end else if (frame_end) begin
        acc_cnt_q   <= 2'd0;
        acc_code_q  <= '0;
        multi_q     <= (cls == MULTI);
        prev_cls_q  <= cls;
        prev_code_q <= code_eff;
        stab_q      <= stab_d;
        case (state_q)
          IDLE: begin
            if (cls == SINGLE && stab_d == STAB_MAX) begin
              key_code_q <= code_eff;
              valid_q    <= 1'b1;
              press_q    <= 1'b1;
              state_q    <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rep_q      <= '0;
`endif
            end
          end
          PRESSED: begin
            // Other keys or MULTI are treated as still held: lockout.
            if (cls == NONE && stab_d == STAB_MAX) begin
              valid_q   <= 1'b0;
              release_q <= 1'b1;
              state_q   <= IDLE;
`ifdef KEYPAD_REPEAT_EN
              rep_q     <= '0;
`endif
            end
`ifdef KEYPAD_REPEAT_EN
            else if (cls == SINGLE && code_eff == key_code_q) begin
              if (rep_q + RP_W'(1) == RP_WRAP) begin
                press_q <= 1'b1;
                rep_q   <= RP_FIRST;
              end else begin
                press_q <= (rep_q + RP_W'(1) == RP_FIRST);
                rep_q   <= rep_q + RP_W'(1);
              end
            end else begin
              rep_q <= '0;
            end
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = valid_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Randomised and directed frames checked against a frame-history model of the scanner.
module tb_keypad_matrix_scan;

  localparam int N_ROW     = 4;
  localparam int N_COL     = 4;
  localparam int SCAN_DIV  = 2;
  localparam int DEB       = 3;
  localparam int REP_DELAY = 16;
  localparam int REP_RATE  = 4;
  localparam int N_KEY     = N_ROW * N_COL;
  localparam int CODE_W    = 4;
  localparam int DWELL     = 1 << SCAN_DIV;
  localparam int FRAME     = DWELL * N_COL;

  logic              clk = 1'b0;
  logic              reset_p = 1'b1;
  logic [N_ROW-1:0]  row;
  logic [N_COL-1:0]  col;
  logic [CODE_W-1:0] key_code;
  logic              key_valid, key_press, key_release, multi_key;

  logic [N_KEY-1:0]  key_mat = '0;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  int hist[$];
  bit m_valid;
  int m_code;
  bit m_multi;
  int m_rep;
  bit e_press, e_release;

  always #5 clk = ~clk;

  keypad_matrix_scan #(
    .N_ROW         (N_ROW),
    .N_COL         (N_COL),
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_DELAY  (REP_DELAY),
    .REPEAT_RATE   (REP_RATE)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .row        (row),
    .col        (col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_press  (key_press),
    .key_release(key_release),
    .multi_key  (multi_key)
  );

  // switch matrix: a closed switch shorts its column strobe onto its row
  always_comb begin
    row = '0;
    for (int c = 0; c < N_COL; c++) begin
      if (col[c]) row = row | key_mat[c*N_ROW +: N_ROW];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_KEY-1:0] one_key(input int k);
    logic [N_KEY-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // -1 = no key, -2 = several keys, otherwise the linear code of the only key
  function automatic int frame_sig(input logic [N_KEY-1:0] m);
    if ($countones(m) == 0) return -1;
    if ($countones(m) > 1) return -2;
    for (int k = 0; k < N_KEY; k++) if (m[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_valid = 1'b0;
    m_code  = 0;
    m_multi = 1'b0;
    m_rep   = 0;
    e_press = 1'b0;
    e_release = 1'b0;
  endtask

  task automatic model_frame(input logic [N_KEY-1:0] m);
    int  sig;
    bit  all_same;
    sig = frame_sig(m);
    m_multi = ($countones(m) > 1);
    hist.push_back(sig);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_same = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != sig) all_same = 1'b0;
    e_press = 1'b0;
    e_release = 1'b0;
    if (!m_valid) begin
      if (sig >= 0 && all_same) begin
        m_valid = 1'b1;
        m_code  = sig;
        e_press = 1'b1;
        m_rep   = 0;
      end
    end else if (sig == -1 && all_same) begin
      m_valid   = 1'b0;
      e_release = 1'b1;
      m_rep     = 0;
    end else begin
`ifdef KEYPAD_REPEAT_EN
      if (sig == m_code) begin
        m_rep++;
        if (m_rep >= REP_DELAY && (m_rep - REP_DELAY) % REP_RATE == 0) e_press = 1'b1;
      end else begin
        m_rep = 0;
      end
`endif
    end
  endtask

  task automatic check_outputs(input int col_idx);
    check("col", col, 32'(1) << col_idx);
    check("key_valid", key_valid, m_valid);
    check("key_code", key_code, m_code);
    check("key_press", key_press, e_press);
    check("key_release", key_release, e_release);
    check("multi_key", multi_key, m_multi);
  endtask

  // Hold matrix m for ncyc cycles from a frame boundary; a full frame is FRAME cycles.
  task automatic run_frame(input logic [N_KEY-1:0] m, input int ncyc);
    key_mat = m;
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk);
      #1;
      if (j == FRAME - 1) begin
        model_frame(m);
      end else begin
        e_press = 1'b0;
        e_release = 1'b0;
      end
      check_outputs(((j + 1) / DWELL) % N_COL);
    end
  endtask

  task automatic do_reset(input int ncyc);
    reset_p = 1'b1;
    model_reset();
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk);
      #1;
      check_outputs(0);
    end
    reset_p = 1'b0;
  endtask

  task automatic frames(input logic [N_KEY-1:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m, FRAME);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N_KEY-1:0] m;
    int r;
    model_reset();

    // reset state and column walk
    do_reset(2);
    frames('0, 2);

    // bouncing switch: closed on alternate frames, never accepted
    for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? one_key(9) : '0, FRAME);
    check("t3_valid", key_valid, 0);

    // col2/row1 held
    frames(one_key(9), 6);
    check("t2_code", key_code, 9);
    check("t2_valid", key_valid, 1);

    // release
    frames('0, 5);
    check("t4_valid", key_valid, 0);
    check("t4_code", key_code, 9);

    // two keys, then one of them opens
    run_frame(one_key(0) | one_key(15), FRAME);
    check("t5_multi", multi_key, 1);
    frames(one_key(0) | one_key(15), 2);
    frames(one_key(0), 4);
    check("t5_code", key_code, 0);
    check("t5_valid", key_valid, 1);
    frames('0, 4);

    // reset in the middle of a hold, key must re-qualify
    frames(one_key(6), 4);
    run_frame(one_key(6), 7);
    do_reset(2);
    frames(one_key(6), 4);
    check("t6_code", key_code, 6);
    frames(one_key(6), 10);
    frames('0, 4);

    // random frames with occasional mid-frame reset
    m = '0;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r >= 5 && r <= 6) m = '0;
      else if (r >= 7 && r <= 8) m = one_key($urandom_range(0, N_KEY - 1));
      else if (r == 9) m = one_key($urandom_range(0, N_KEY - 1)) | one_key($urandom_range(0, N_KEY - 1));
      if ($urandom_range(0, 49) == 0) begin
        run_frame(m, $urandom_range(1, FRAME - 1));
        do_reset($urandom_range(1, 3));
      end else begin
        run_frame(m, FRAME);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
